// File: rtl/string_to_board_if.sv
// Character-in / board-out bundle between the UART receive path and the board parser.
interface string_to_board_if;
  logic [7:0]   char_in;
  logic         char_valid;
  logic [319:0] board;
  logic         board_valid;
  logic [4:0]   tiles_loaded;
  logic         busy;
  logic         error;

  modport master (
    output char_in, char_valid,
    input  board, board_valid, tiles_loaded, busy, error
  );

  modport slave (
    input  char_in, char_valid,
    output board, board_valid, tiles_loaded, busy, error
  );
endinterface

// File: rtl/string_to_board.sv
// ASCII decimal stream to packed 16 x 20-bit board, committed atomically per frame.
// Optional build macro STRING_TO_BOARD_POW2_CHECK_EN: tiles must be 0 or a power of two >= 2.
module string_to_board (
  input logic               clk,
  input logic               rst,
  string_to_board_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, NUM, ERR} state_t;
  typedef enum logic [1:0] {C_DIGIT, C_DELIM, C_ABORT, C_INVALID} cls_t;

  function automatic cls_t classify(input logic [7:0] c);
    cls_t r;
    if (c >= 8'h30 && c <= 8'h39)
      r = C_DIGIT;
    else if (c == 8'h20 || c == 8'h2C || c == 8'h7C || c == 8'h2D ||
             c == 8'h0A || c == 8'h0D)
      r = C_DELIM;
    else if (c == 8'h1B)
      r = C_ABORT;
    else
      r = C_INVALID;
    return r;
  endfunction

  // 24-bit headroom: 0xFFFFF*10+9 still fits, so overflow is a plain compare.
  function automatic logic [23:0] acc_step(input logic [19:0] acc, input logic [3:0] dig);
    logic [23:0] wide;
    wide = {4'd0, acc};
    return (wide * 24'd10) + {20'd0, dig};
  endfunction

  function automatic logic is_newline(input logic [7:0] c);
    return (c == 8'h0A) || (c == 8'h0D);
  endfunction

`ifdef STRING_TO_BOARD_POW2_CHECK_EN
  function automatic logic tile_legal(input logic [19:0] v);
    return (v == 20'd0) || ((v != 20'd1) && ((v & (v - 20'd1)) == 20'd0));
  endfunction
`endif

  state_t         state_q, state_d;
  logic [19:0]    acc_q, acc_d;
  logic [3:0]     idx_q, idx_d;
  logic [319:0]   shadow_q, shadow_d;
  logic [319:0]   board_q;
  logic           board_valid_q;
  logic           commit;
  logic           tile_ok;
  logic [23:0]    step;
  cls_t           cls;

`ifdef STRING_TO_BOARD_POW2_CHECK_EN
  assign tile_ok = tile_legal(acc_q);
`else
  assign tile_ok = 1'b1;
`endif

  assign step = acc_step(acc_q, bus.char_in[3:0]);
  assign cls  = classify(bus.char_in);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    commit   = 1'b0;
    if (bus.char_valid) begin
      unique case (state_q)
        IDLE: begin
          unique case (cls)
            C_DIGIT: begin
              acc_d   = {16'd0, bus.char_in[3:0]};
              state_d = NUM;
            end
            C_ABORT:   idx_d   = 4'd0;
            C_INVALID: state_d = ERR;
            default: ;
          endcase
        end
        NUM: begin
          unique case (cls)
            C_DIGIT: begin
              if (step > 24'h0FFFFF)
                state_d = ERR;
              else
                acc_d = step[19:0];
            end
            C_DELIM: begin
              if (!tile_ok) begin
                state_d = ERR;
              end else begin
                shadow_d[idx_q*20 +: 20] = acc_q;
                state_d = IDLE;
                // The last tile closes the frame; the next character starts a new one.
                if (idx_q == 4'd15) begin
                  commit = 1'b1;
                  idx_d  = 4'd0;
                end else begin
                  idx_d  = idx_q + 4'd1;
                end
              end
            end
            C_ABORT: begin
              acc_d   = 20'd0;
              idx_d   = 4'd0;
              state_d = IDLE;
            end
            default: state_d = ERR;
          endcase
        end
        ERR: begin
          if (is_newline(bus.char_in)) begin
            acc_d   = 20'd0;
            idx_d   = 4'd0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_q         <= 20'd0;
      idx_q         <= 4'd0;
      shadow_q      <= '0;
      board_q       <= '0;
      board_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      board_valid_q <= commit;
      if (commit)
        board_q <= shadow_d;
    end
  end

  assign bus.board        = board_q;
  assign bus.board_valid  = board_valid_q;
  assign bus.tiles_loaded = {1'b0, idx_q};
  assign bus.busy         = (state_q == NUM) || (idx_q != 4'd0);
  assign bus.error        = (state_q == ERR);
endmodule

// File: tb/tb_string_to_board.sv
// Directed bench for string_to_board with a commit scoreboard.
module tb_string_to_board;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  string_to_board_if bus();
  string_to_board dut (.clk(clk), .rst(rst), .bus(bus));

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int n_pulse = 0;
  logic [319:0] sb[$];
  logic [19:0]  tiles [16];
  logic [319:0] cur_board = '0;
  logic [319:0] exp_b;
  int pulses_before;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [319:0] pack_tiles();
    logic [319:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b[i*20 +: 20] = tiles[i];
    return b;
  endfunction

  task automatic send_char(input byte c);
    @(negedge clk);
    bus.char_in    = c;
    bus.char_valid = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.char_valid = 1'b0;
    end
  endtask

  // Sends tiles[] as a frame; the final terminator commits it.
  task automatic send_frame(input string sep, input string term);
    for (int i = 0; i < 16; i++) begin
      send_str($sformatf("%0d", tiles[i]));
      send_str(i == 15 ? term : sep);
    end
    sb.push_back(pack_tiles());
  endtask

  always @(negedge clk) begin
    if (!rst && bus.board_valid) begin
      n_pulse++;
      if (sb.size() == 0)
        chk("unexpected_commit", 320'd1, 320'd0);
      else
        chk("sb_board", bus.board, sb.pop_front());
    end
  end

  initial begin
    bus.char_in    = 8'h00;
    bus.char_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_board", bus.board, 320'd0);
    chk("rst_valid", 320'(bus.board_valid), 320'd0);
    chk("rst_tiles", 320'(bus.tiles_loaded), 320'd0);
    chk("rst_busy", 320'(bus.busy), 320'd0);
    chk("rst_error", 320'(bus.error), 320'd0);
    rst = 1'b0;

    // Frame 1: mixed delimiters, ends with newline.
    tiles[0] = 20'd2; tiles[1] = 20'd4; tiles[2] = 20'd0;
    for (int i = 3; i < 16; i++) tiles[i] = 20'(1 << i);
    send_str("5");
    idle(1);
    chk("num_busy", 320'(bus.busy), 320'd1);
    chk("num_tiles", 320'(bus.tiles_loaded), 320'd0);
    send_char(8'h1B);
    idle(1);
    chk("esc_from_num_busy", 320'(bus.busy), 320'd0);
    pulses_before = n_pulse;
    send_frame("|", "\n");
    cur_board = pack_tiles();
    idle(1);
    chk("f1_valid_pulse", 320'(bus.board_valid), 320'd1);
    chk("f1_board", bus.board, cur_board);
    chk("f1_tile0", 320'(bus.board[19:0]), 320'd2);
    chk("f1_tile1", 320'(bus.board[39:20]), 320'd4);
    chk("f1_tile15", 320'(bus.board[319:300]), 320'd32768);
    chk("f1_tiles_back_0", 320'(bus.tiles_loaded), 320'd0);
    idle(1);
    chk("f1_valid_fall", 320'(bus.board_valid), 320'd0);
    chk("f1_one_pulse", 320'(n_pulse - pulses_before), 320'd1);

    // Frame 2: leading zeros, back-to-back strobes.
    pulses_before = n_pulse;
    for (int i = 0; i < 16; i++) begin
      tiles[i] = 20'd2;
      send_str("0002 ");
    end
    sb.push_back(pack_tiles());
    cur_board = pack_tiles();
    idle(3);
    chk("f2_board", bus.board, cur_board);
    chk("f2_one_pulse", 320'(n_pulse - pulses_before), 320'd1);

    // Overflow on the 7th digit.
    send_str("104857");
    idle(1);
    chk("ovf_pre_error", 320'(bus.error), 320'd0);
    send_str("6");
    idle(1);
    chk("ovf_error", 320'(bus.error), 320'd1);
    send_str(" 12 ");
    idle(1);
    chk("err_discard", 320'(bus.error), 320'd1);
    chk("ovf_board_kept", bus.board, cur_board);
    send_str("\n");
    idle(1);
    chk("ovf_recover", 320'(bus.error), 320'd0);
    for (int i = 0; i < 16; i++) tiles[i] = 20'(1 << ((i % 19) + 1));
    tiles[5] = 20'd0;
    send_frame(",", " ");
    cur_board = pack_tiles();
    idle(2);
    chk("f3_board", bus.board, cur_board);

    // Five tiles then an invalid character.
    send_str("8 8 8 8 8 ");
    idle(1);
    chk("five_tiles", 320'(bus.tiles_loaded), 320'd5);
    send_str("x");
    idle(1);
    chk("invalid_error", 320'(bus.error), 320'd1);
    send_str("\r");
    idle(1);
    chk("cr_recover", 320'(bus.error), 320'd0);
    chk("cr_tiles", 320'(bus.tiles_loaded), 320'd0);
    for (int i = 0; i < 16; i++) tiles[i] = 20'(1 << ($urandom_range(1, 19)));
    tiles[15] = 20'd1048576 >> 1;
    send_frame("-", "\r");
    cur_board = pack_tiles();
    idle(2);
    chk("f4_board", bus.board, cur_board);

    // Seven tiles then ESC.
    send_str("2 2 2 2 2 2 2 ");
    idle(1);
    chk("seven_tiles", 320'(bus.tiles_loaded), 320'd7);
    send_char(8'h1B);
    idle(1);
    chk("esc_tiles", 320'(bus.tiles_loaded), 320'd0);
    chk("esc_busy", 320'(bus.busy), 320'd0);
    chk("esc_board_kept", bus.board, cur_board);

    // Tile value 6.
    send_str("6 ");
    idle(1);
`ifdef STRING_TO_BOARD_POW2_CHECK_EN
    chk("pow2_reject", 320'(bus.error), 320'd1);
    send_str("\n");
    idle(1);
    chk("pow2_board_kept", bus.board, cur_board);
`else
    chk("six_accepted", 320'(bus.tiles_loaded), 320'd1);
    tiles[0] = 20'd6;
    for (int i = 1; i < 16; i++) begin
      tiles[i] = 20'd4;
      send_str("4 ");
    end
    sb.push_back(pack_tiles());
    cur_board = pack_tiles();
    idle(2);
    chk("six_board", bus.board, cur_board);
`endif

    // Reset mid-frame.
    send_str("4 4 4 1");
    idle(1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_board", bus.board, 320'd0);
    chk("rst_mid_tiles", 320'(bus.tiles_loaded), 320'd0);
    chk("rst_mid_busy", 320'(bus.busy), 320'd0);

    idle(3);
    chk("sb_drained", 320'(sb.size()), 320'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
